ps2_command_buffer: RTL and testbench
=====================================

# ps2_command_buffer

Line-editing command front end between the PS/2 keyboard path and the processor. It accepts one decoded ASCII keystroke per strobe and builds a command line of up to `CHARS` characters, with backspace and escape editing. On Enter it commits the line into a `QDEPTH`-entry command queue, which the processor drains through a ready/ack handshake. Each accepted edit is also echoed as a one-cycle strobe for the LCD path.

## Interface
Parameters:
- `CHARS`, default 4: maximum characters per command line; ≥1.
- `QDEPTH`, default 4: command queue entries; power of two, ≥2.
- `CMD_W`, derived, = `CHARS*8`: packed command width (32 at default).
- `LEN_W`, derived, = `$clog2(CHARS+1)`: width of length fields.

Ports:
- `clock`, in, 1: single clock; all state on its rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `key_valid`, in, 1: one-cycle strobe, one per keystroke.
- `key_ascii`, in, 8: ASCII code, qualified by `key_valid`.
- `cmd_ready`, out, 1: queue non-empty; head entry valid.
- `cmd_data`, out, `CMD_W`: head command, packed.
- `cmd_len`, out, `LEN_W`: head command character count, 1..`CHARS`.
- `cmd_ack`, in, 1: pop the head entry; ignored when `cmd_ready`=0.
- `line_len`, out, `LEN_W`: characters currently in the edit line.
- `echo_valid`, out, 1: one-cycle strobe, an edit was accepted.
- `echo_ascii`, out, 8: the accepted code.
- `err_line_full`, out, 1: one-cycle pulse, printable key dropped.
- `err_queue_full`, out, 1: one-cycle pulse, Enter refused.

## Operation
The edit line is decoded on `key_valid`:
- **Printable (0x20–0x7E):**
  - If `line_len`<`CHARS`: store at byte index `line_len`, increment `line_len`, echo the key.
  - Otherwise: drop the key and pulse `err_line_full`; no echo.
- **0x08 backspace:**
  - If `line_len`>0: decrement `line_len`, zero the vacated byte, echo 0x08.
  - Otherwise: no effect.
- **0x0D Enter:**
  - If `line_len`=0: ignored.
  - Else if the queue accepts the push: push {line, `line_len`}, clear the line to all zeros with `line_len`=0, echo 0x0D.
  - Else: pulse `err_queue_full`, keep the line unchanged (so Enter can be retried), no echo.
- **0x1B escape:** clear the line, echo 0x1B.
- **All other codes:** ignored silently.

Packing:
- Character 0 sits in `cmd_data[7:0]` and character i in `[8i+7:8i]`.
- Unused high bytes are 0x00.

Queue:
- First-word-fall-through: `cmd_data` and `cmd_len` are the head entry whenever `cmd_ready`=1.
- When the queue is empty, `cmd_data` and `cmd_len` read 0.
- Occupancy update: count_next = count + push − pop.
- A push while full is accepted if `cmd_ack` pops in the same cycle. It is refused only when full and there is no pop.
- Read and write pointers wrap modulo `QDEPTH`.

Edge cases:
- Back-to-back `key_valid` strobes are each processed; there is no backpressure toward the keyboard.
- `key_valid` and `cmd_ack` in the same cycle are processed independently, subject to the count rule above.

## Timing
- Reset values: `cmd_ready`=0, `cmd_data`=0, `cmd_len`=0, `line_len`=0, `echo_valid`=0, `echo_ascii`=0, both error pulses 0.
  - The line buffer and queue are empty.
  - Pointers and count are 0.
- Reset asserted mid-line or mid-handshake discards all content immediately, asynchronously.
- A keystroke with `key_valid` in cycle n:
  - `line_len`, `echo_*` and `err_*` update at the edge ending cycle n, so they are visible in cycle n+1.
  - Echo and error pulses last exactly one cycle.
- Enter in cycle n into an empty queue: `cmd_ready`=1 and head data are valid in cycle n+1.
- `cmd_ack` in cycle n with `cmd_ready`=1: the next entry, or `cmd_ready`=0, is visible in cycle n+1.

## Structure
- Shared package `ps2_cmd_pkg` holds:
  - ASCII constants: `ASCII_BS`=8'h08, `ASCII_CR`=8'h0D, `ASCII_ESC`=8'h1B, `ASCII_PRINT_LO`=8'h20, `ASCII_PRINT_HI`=8'h7E.
  - A key-class enum: PRINT, BS, CR, ESC, OTHER.
- Sub-module `cmd_fifo`:
  - Parameterised by WIDTH (`CMD_W+LEN_W`) and DEPTH (`QDEPTH`).
  - Has the same clock and reset as this block.
  - Ports: push, pop, full, empty, head.
- The line editor (buffer, length register, classifier, echo and error registers) stays in the top.

## Test plan
1. Type 'F','D', then 0x0D → echoes 0x46, 0x44, 0x0D; next cycle `cmd_ready`=1, `cmd_data`=32'h00004446, `cmd_len`=2, `line_len`=0; `cmd_ack` → `cmd_ready`=0.
2. Type 'A','B',0x08,'C',0x0D → `cmd_data`=32'h00004341, `cmd_len`=2; 0x08 with an empty line produces no echo.
3. Type 'W','X','Y','Z','Q' → the fifth key pulses `err_line_full`, `line_len` stays 4; Enter gives `cmd_data`=32'h5A595857.
4. Commit four one-char commands with no ack, type 'E', then 0x0D → `err_queue_full` pulses and `line_len` stays 1; then 0x0D together with `cmd_ack` in one cycle → push accepted, count stays 4.
5. Type 'A','B', assert `reset` asynchronously mid-cycle → all outputs 0 immediately; after release, 0x0D is ignored.
6. Type 'A', 0x1B, key 0x07 → 0x1B echoed and `line_len`=0; 0x07 produces no echo or error; then 16 commit/ack cycles verify pointer wrap with correct data order.

Source files
------------

// File: rtl/ps2_cmd_pkg.sv
// Shared ASCII constants and key classification for the PS/2 command line editor.
package ps2_cmd_pkg;

  localparam logic [7:0] ASCII_BS       = 8'h08;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_ESC      = 8'h1B;
  localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
  localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

  typedef enum logic [2:0] {PRINT, BS, CR, ESC, OTHER} key_class_e;

  function automatic key_class_e classify(input logic [7:0] c);
    if (c >= ASCII_PRINT_LO && c <= ASCII_PRINT_HI) return PRINT;
    if (c == ASCII_BS)  return BS;
    if (c == ASCII_CR)  return CR;
    if (c == ASCII_ESC) return ESC;
    return OTHER;
  endfunction

endpackage

// File: rtl/ps2_command_buffer_cmd_fifo.sv
// First-word-fall-through command queue; a push while full succeeds if a pop happens the same cycle.
module cmd_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (PTR_W+1)'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    head     = empty ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head is masked to zero while empty.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ps2_command_buffer.sv
// Line-editing front end: builds a command line from keystrokes and commits it to a command queue on Enter.
module ps2_command_buffer
  import ps2_cmd_pkg::*;
#(
  parameter  int CHARS  = 4,
  parameter  int QDEPTH = 4,
  localparam int CMD_W  = CHARS*8,
  localparam int LEN_W  = $clog2(CHARS+1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [7:0]       key_ascii,
  output logic             cmd_ready,
  output logic [CMD_W-1:0] cmd_data,
  output logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_ack,
  output logic [LEN_W-1:0] line_len,
  output logic             echo_valid,
  output logic [7:0]       echo_ascii,
  output logic             err_line_full,
  output logic             err_queue_full
);

  logic [CMD_W-1:0] line_q, line_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             echo_valid_q, echo_valid_d;
  logic [7:0]       echo_ascii_q, echo_ascii_d;
  logic             err_lf_q, err_lf_d, err_qf_q, err_qf_d;
  logic             push, pop_ok, fifo_full, fifo_empty;
  logic [CMD_W+LEN_W-1:0] head;

  cmd_fifo #(.WIDTH(CMD_W+LEN_W), .DEPTH(QDEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({len_q, line_q}),
    .pop       (cmd_ack),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  always_comb begin
    line_d       = line_q;
    len_d        = len_q;
    echo_valid_d = 1'b0;
    echo_ascii_d = echo_ascii_q;
    err_lf_d     = 1'b0;
    err_qf_d     = 1'b0;
    push         = 1'b0;
    pop_ok       = cmd_ack && !fifo_empty;
    if (key_valid) begin
      case (classify(key_ascii))
        PRINT: begin
          if (len_q < LEN_W'(CHARS)) begin
            for (int unsigned i = 0; i < CHARS; i++)
              if (LEN_W'(i) == len_q) line_d[8*i +: 8] = key_ascii;
            len_d        = len_q + 1'b1;
            echo_valid_d = 1'b1;
            echo_ascii_d = key_ascii;
          end else begin
            err_lf_d = 1'b1;
          end
        end
        BS: begin
          if (len_q != '0) begin
            for (int unsigned i = 0; i < CHARS; i++)
              if (LEN_W'(i+1) == len_q) line_d[8*i +: 8] = '0;
            len_d        = len_q - 1'b1;
            echo_valid_d = 1'b1;
            echo_ascii_d = ASCII_BS;
          end
        end
        CR: begin
          if (len_q != '0) begin
            // Same-cycle ack frees a slot, so a full queue can still take this line.
            if (!fifo_full || pop_ok) begin
              push         = 1'b1;
              line_d       = '0;
              len_d        = '0;
              echo_valid_d = 1'b1;
              echo_ascii_d = ASCII_CR;
            end else begin
              err_qf_d = 1'b1;
            end
          end
        end
        ESC: begin
          line_d       = '0;
          len_d        = '0;
          echo_valid_d = 1'b1;
          echo_ascii_d = ASCII_ESC;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      line_q       <= '0;
      len_q        <= '0;
      echo_valid_q <= 1'b0;
      echo_ascii_q <= '0;
      err_lf_q     <= 1'b0;
      err_qf_q     <= 1'b0;
    end else begin
      line_q       <= line_d;
      len_q        <= len_d;
      echo_valid_q <= echo_valid_d;
      echo_ascii_q <= echo_ascii_d;
      err_lf_q     <= err_lf_d;
      err_qf_q     <= err_qf_d;
    end
  end

  assign cmd_ready      = !fifo_empty;
  assign cmd_data       = head[CMD_W-1:0];
  assign cmd_len        = head[CMD_W +: LEN_W];
  assign line_len       = len_q;
  assign echo_valid     = echo_valid_q;
  assign echo_ascii     = echo_ascii_q;
  assign err_line_full  = err_lf_q;
  assign err_queue_full = err_qf_q;

endmodule

// File: tb/tb_ps2_command_buffer.sv
// Bench for ps2_command_buffer: directed keystrokes checked every cycle against a queue-based model.
module tb_ps2_command_buffer;

  localparam int CHARS  = 4;
  localparam int QDEPTH = 4;

  logic        clock, reset;
  logic        key_valid;
  logic [7:0]  key_ascii;
  logic        cmd_ack;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic [2:0]  cmd_len;
  logic [2:0]  line_len;
  logic        echo_valid;
  logic [7:0]  echo_ascii;
  logic        err_line_full, err_queue_full;

  ps2_command_buffer #(.CHARS(CHARS), .QDEPTH(QDEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .key_valid      (key_valid),
    .key_ascii      (key_ascii),
    .cmd_ready      (cmd_ready),
    .cmd_data       (cmd_data),
    .cmd_len        (cmd_len),
    .cmd_ack        (cmd_ack),
    .line_len       (line_len),
    .echo_valid     (echo_valid),
    .echo_ascii     (echo_ascii),
    .err_line_full  (err_line_full),
    .err_queue_full (err_queue_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: line as a byte array, queue as a SystemVerilog queue of entries.
  typedef struct {
    logic [31:0] data;
    int          len;
  } entry_t;

  logic [7:0] m_line [CHARS];
  int         m_len;
  entry_t     m_q[$];
  bit         m_echo_v, m_elf, m_eqf;
  logic [7:0] m_echo_a;
  bit         m_pop, m_push;
  entry_t     m_e;
  logic [7:0] m_k;

  function automatic logic [31:0] pack_line();
    logic [31:0] d = '0;
    for (int i = 0; i < CHARS; i++) d = d | (32'(m_line[i]) << (8*i));
    return d;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHARS; i++) m_line[i] = 8'h00;
      m_len = 0; m_q.delete();
      m_echo_v = 0; m_echo_a = 8'h00; m_elf = 0; m_eqf = 0;
    end else begin
      m_pop  = cmd_ack && (m_q.size() > 0);
      m_push = 0;
      m_echo_v = 0; m_elf = 0; m_eqf = 0;
      if (key_valid) begin
        m_k = key_ascii;
        if (m_k >= 8'h20 && m_k <= 8'h7E) begin
          if (m_len < CHARS) begin
            m_line[m_len] = m_k; m_len++;
            m_echo_v = 1; m_echo_a = m_k;
          end else m_elf = 1;
        end else if (m_k == 8'h08) begin
          if (m_len > 0) begin
            m_len--; m_line[m_len] = 8'h00;
            m_echo_v = 1; m_echo_a = 8'h08;
          end
        end else if (m_k == 8'h0D) begin
          if (m_len > 0) begin
            if (m_q.size() < QDEPTH || m_pop) begin
              m_e.data = pack_line(); m_e.len = m_len; m_push = 1;
              for (int i = 0; i < CHARS; i++) m_line[i] = 8'h00;
              m_len = 0;
              m_echo_v = 1; m_echo_a = 8'h0D;
            end else m_eqf = 1;
          end
        end else if (m_k == 8'h1B) begin
          for (int i = 0; i < CHARS; i++) m_line[i] = 8'h00;
          m_len = 0;
          m_echo_v = 1; m_echo_a = 8'h1B;
        end
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_push) m_q.push_back(m_e);
    end
  end

  always @(negedge clock) begin
    if (check_en && !reset) begin
      chk("m_cmd_ready", 64'(cmd_ready), 64'(m_q.size() > 0));
      chk("m_cmd_data",  64'(cmd_data),  (m_q.size() > 0) ? 64'(m_q[0].data) : 64'h0);
      chk("m_cmd_len",   64'(cmd_len),   (m_q.size() > 0) ? 64'(m_q[0].len)  : 64'h0);
      chk("m_line_len",  64'(line_len),  64'(m_len));
      chk("m_echo_valid", 64'(echo_valid), 64'(m_echo_v));
      if (m_echo_v) chk("m_echo_ascii", 64'(echo_ascii), 64'(m_echo_a));
      chk("m_err_line_full",  64'(err_line_full),  64'(m_elf));
      chk("m_err_queue_full", 64'(err_queue_full), 64'(m_eqf));
    end
  end

  task automatic cyc(input logic kv, input logic [7:0] ka, input logic ack);
    @(negedge clock);
    key_valid = kv; key_ascii = ka; cmd_ack = ack;
  endtask

  task automatic key(input logic [7:0] ka);
    cyc(1'b1, ka, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic ack();
    cyc(1'b0, 8'h00, 1'b1);
  endtask

  logic [31:0] exp_d;

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_ascii = 8'h00; cmd_ack = 1'b0;
    #12;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'h0);
    chk("rst_cmd_data",  64'(cmd_data),  64'h0);
    chk("rst_line_len",  64'(line_len),  64'h0);
    chk("rst_echo",      64'({echo_valid, echo_ascii}), 64'h0);
    @(negedge clock); #1 reset = 1'b0;
    check_en = 1;

    // 1: "FD" Enter, then ack
    key(8'h46); key(8'h44); key(8'h0D); idle();
    chk("t1_ready", 64'(cmd_ready), 64'h1);
    chk("t1_data",  64'(cmd_data),  64'h00004446);
    chk("t1_len",   64'(cmd_len),   64'h2);
    chk("t1_line",  64'(line_len),  64'h0);
    chk("t1_echo",  64'(echo_ascii), 64'h0D);
    ack(); idle();
    chk("t1_drained", 64'(cmd_ready), 64'h0);

    // 2: backspace on empty line, then AB<BS>C Enter
    key(8'h08); idle();
    chk("t2_bs_empty_echo", 64'(echo_valid), 64'h0);
    key(8'h41); key(8'h42); key(8'h08); key(8'h43); key(8'h0D); idle();
    chk("t2_data", 64'(cmd_data), 64'h00004341);
    chk("t2_len",  64'(cmd_len),  64'h2);
    ack(); idle();

    // 3: line overflow
    key(8'h57); key(8'h58); key(8'h59); key(8'h5A); key(8'h51); idle();
    chk("t3_err_line_full", 64'(err_line_full), 64'h1);
    chk("t3_line_len",      64'(line_len),      64'h4);
    key(8'h0D); idle();
    chk("t3_data", 64'(cmd_data), 64'h5A595857);
    chk("t3_len",  64'(cmd_len),  64'h4);
    ack(); idle();

    // 4: fill the queue, refused Enter, then Enter with same-cycle ack
    for (int i = 0; i < 4; i++) begin key(8'(8'h61 + i)); key(8'h0D); end
    key(8'h45); key(8'h0D); idle();
    chk("t4_err_queue_full", 64'(err_queue_full), 64'h1);
    chk("t4_line_len",       64'(line_len),       64'h1);
    chk("t4_no_echo",        64'(echo_valid),     64'h0);
    cyc(1'b1, 8'h0D, 1'b1); idle();
    chk("t4_push_pop_line", 64'(line_len), 64'h0);
    chk("t4_push_pop_head", 64'(cmd_data), 64'h62);
    chk("t4_push_pop_echo", 64'(echo_ascii), 64'h0D);
    ack(); ack(); ack(); idle();
    chk("t4_tail_data", 64'(cmd_data), 64'h45);
    chk("t4_tail_len",  64'(cmd_len),  64'h1);
    ack(); idle();
    chk("t4_empty", 64'(cmd_ready), 64'h0);

    // 5: asynchronous reset mid-line with a queued command
    key(8'h5A); key(8'h0D); key(8'h41); key(8'h42);
    @(posedge clock); #2 reset = 1'b1;
    key_valid = 1'b0; key_ascii = 8'h00; cmd_ack = 1'b0;
    #1;
    chk("t5_rst_ready", 64'(cmd_ready), 64'h0);
    chk("t5_rst_data",  64'(cmd_data),  64'h0);
    chk("t5_rst_len",   64'(cmd_len),   64'h0);
    chk("t5_rst_line",  64'(line_len),  64'h0);
    chk("t5_rst_echo",  64'({echo_valid, echo_ascii}), 64'h0);
    chk("t5_rst_errs",  64'({err_line_full, err_queue_full}), 64'h0);
    @(negedge clock); #1 reset = 1'b0;
    key(8'h0D); idle();
    chk("t5_cr_ignored_echo",  64'(echo_valid), 64'h0);
    chk("t5_cr_ignored_ready", 64'(cmd_ready),  64'h0);

    // 6: escape, unknown code, pointer wrap
    key(8'h41); key(8'h1B); idle();
    chk("t6_esc_echo", 64'(echo_ascii), 64'h1B);
    chk("t6_esc_line", 64'(line_len),   64'h0);
    key(8'h07); idle();
    chk("t6_other_quiet", 64'({echo_valid, err_line_full, err_queue_full}), 64'h0);
    for (int i = 0; i < 16; i++) begin
      key(8'(8'h61 + i));
      if (i % 2 == 1) key(8'(8'h41 + i));
      key(8'h0D); idle();
      exp_d = (i % 2 == 1) ? {16'h0, 8'(8'h41 + i), 8'(8'h61 + i)} : 32'(8'(8'h61 + i));
      chk("t6_wrap_data", 64'(cmd_data), 64'(exp_d));
      ack();
    end
    idle();
    chk("t6_final_empty", 64'(cmd_ready), 64'h0);

    check_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
